// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t : responder FSM states (IDLE, WAIT, RESP)
//   op_t    : decoded request class (OP_RD, OP_WR, OP_BAD)
//   DATA_W / ADDR_W / CNT_W : data, address and statistics counter widths
//   decode_op : turns the MemRead/MemWrite pair into an op_t
//   sat_inc   : saturating increment for the statistics counters
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_BAD
  } op_t;

  // Asking for a read and a write at once is not a meaningful access,
  // so it gets its own class and is rejected later.
  function automatic op_t decode_op(input logic rd, input logic wr);
    if (rd && wr) return OP_BAD;
    else if (wr)  return OP_WR;
    else          return OP_RD;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else                    return v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_storage.sv
// dmem_storage: DEPTH_WORDS x 32 word array.
//   clock : rising-edge clock
//   reset : synchronous active-high reset; clears only the read register
//   we    : write strobe, writes wdata into word idx
//   re    : read strobe, loads word idx into the read register
//   idx   : word index shared by both ports
//   wdata : write data
//   rdata : registered read data, held until the next read strobe
module dmem_storage
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // The array itself has no reset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
  end

  // The read register doubles as the load-data output, so it keeps its
  // value across writes and rejected accesses.
  always_ff @(posedge clock) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the CPU load/store port.
//   clock      : rising-edge clock
//   Reset      : synchronous active-high reset (RAM contents survive it)
//   MemRead    : read request, sampled only while idle
//   MemWrite   : write request, sampled only while idle
//   Address    : byte address of the request
//   Write_data : store data
//   Read_data  : load data, updated only by successful reads
//   mem_ready  : one-cycle response pulse, WAIT_CYCLES+1 cycles after acceptance
//   mem_error  : qualifies mem_ready; 1 means the access was rejected
//   busy       : high while a request is in flight (WAIT and RESP)
// Optional build macro DMEM_STATS_EN adds rd_count, wr_count and err_count,
// saturating 16-bit response counters cleared by Reset.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Write_data,
  output logic [DATA_W-1:0] Read_data,
  output logic              mem_ready,
  output logic              mem_error,
  output logic              busy
`ifdef DMEM_STATS_EN
  ,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  err_count
`endif
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state;
  logic [3:0]        wait_cnt;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  op_t               cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [ADDR_W-1:0] offset;
  logic              req_bad;
  logic              enter_resp;
  logic              ram_we;
  logic              ram_re;

  // With zero wait states the response edge is the accepting edge itself,
  // so the checks must look at the live inputs while idle and at the
  // latched copy afterwards.
  always_comb begin
    accept    = (state == IDLE) && (MemRead || MemWrite);
    cur_op    = (state == IDLE) ? decode_op(MemRead, MemWrite) : op_q;
    cur_addr  = (state == IDLE) ? Address    : addr_q;
    cur_wdata = (state == IDLE) ? Write_data : wdata_q;
    offset    = cur_addr - BASE_ADDR;
    req_bad   = (cur_op == OP_BAD)
             || (cur_addr[1:0] != 2'b00)
             || (cur_addr < BASE_ADDR)
             || ({2'b00, offset[ADDR_W-1:2]} >= 32'(DEPTH_WORDS));
    enter_resp = ((state == IDLE) && accept && (WAIT_CYCLES == 0))
              || ((state == WAIT) && (wait_cnt == 4'd0));
    ram_we = enter_resp && !Reset && !req_bad && (cur_op == OP_WR);
    ram_re = enter_resp && !Reset && !req_bad && (cur_op == OP_RD);
  end

  dmem_storage #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_storage (
    .clock(clock),
    .reset(Reset),
    .we   (ram_we),
    .re   (ram_re),
    .idx  (offset[IDX_W+1:2]),
    .wdata(cur_wdata),
    .rdata(Read_data)
  );

  // Request FSM; mem_ready, mem_error and busy are registered so they line
  // up with the RESP state.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_ready <= enter_resp;
      mem_error <= enter_resp && req_bad;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= cur_op;
            addr_q  <= Address;
            wdata_q <= Write_data;
            busy    <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_STATS_EN
  // Counters step on the same edge that raises mem_ready, so they already
  // include the response being signalled.
  always_ff @(posedge clock) begin
    if (Reset) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (enter_resp) begin
      if (req_bad)                err_count <= sat_inc(err_count);
      else if (cur_op == OP_RD)   rd_count  <= sat_inc(rd_count);
      else                        wr_count  <= sat_inc(wr_count);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: bench for dmem_responder.
// Two instances share the clock: dut0 with two wait states and dut1 with
// none. Build with DMEM_STATS_EN to include the statistics counters.
module tb_dmem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clock;
  logic        reset0, rd0, wr0, ready0, err0, busy0;
  logic [31:0] addr0, wd0, rdata0;
  logic        reset1, rd1, wr1, ready1, err1, busy1;
  logic [31:0] addr1, wd1, rdata1;
`ifdef DMEM_STATS_EN
  logic [15:0] rdc0, wrc0, erc0, rdc1, wrc1, erc1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model: one pending request per instance, its response
  // cycle, and a byte-addressed view of memory and load data.
  bit          pend [2];
  int          acc [2];
  bit          p_rd [2], p_wr [2], p_err [2];
  logic [31:0] p_addr [2], p_data [2];
  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] rd_m [2];
  int          last_rdy_dut [2];
  logic [15:0] rd_c [2], wr_c [2], er_c [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) dut0 (
    .clock(clock), .Reset(reset0), .MemRead(rd0), .MemWrite(wr0),
    .Address(addr0), .Write_data(wd0), .Read_data(rdata0),
    .mem_ready(ready0), .mem_error(err0), .busy(busy0)
`ifdef DMEM_STATS_EN
    , .rd_count(rdc0), .wr_count(wrc0), .err_count(erc0)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut1 (
    .clock(clock), .Reset(reset1), .MemRead(rd1), .MemWrite(wr1),
    .Address(addr1), .Write_data(wd1), .Read_data(rdata1),
    .mem_ready(ready1), .mem_error(err1), .busy(busy1)
`ifdef DMEM_STATS_EN
    , .rd_count(rdc1), .wr_count(wrc1), .err_count(erc1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin rd0 = r; wr0 = w; addr0 = a; wd0 = d; end
    else        begin rd1 = r; wr1 = w; addr1 = a; wd1 = d; end
  endtask

  // Classify a request purely from the byte address rules.
  task automatic model_request(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    off       = a - BASE;
    pend[i]   = 1'b1;
    acc[i]    = cyc;
    p_rd[i]   = r && !w;
    p_wr[i]   = w && !r;
    p_addr[i] = a;
    p_data[i] = d;
    p_err[i]  = (r && w) || (a[1:0] != 2'b00) || (a < BASE) || (off >= 32'(4 * DEPTH));
  endtask

  // Present a request while the DUT is idle and return once it is idle
  // again. Without hold, the inputs are scrambled after acceptance.
  task automatic applyStimulus(input int i, input bit r, input bit w, input logic [31:0] a,
                               input logic [31:0] d, input bit hold, output int n);
    drive(i, r, w, a, d);
    model_request(i, r, w, a, d);
    n = cyc;
    @(posedge clock); #1;
    if (!hold) drive(i, 1'b0, 1'b0, ~a, ~d);
    repeat (wc(i) + 1) @(posedge clock);
    #1;
  endtask

  task automatic cmp_inst(input int i, input bit rs, input logic [31:0] rdv, input logic rdy,
                          input logic er, input logic bz
`ifdef DMEM_STATS_EN
                          , input logic [15:0] rc, input logic [15:0] wcn, input logic [15:0] ec
`endif
                          );
    bit e_rdy, e_err, e_bz;
    logic [31:0] off;
    if (rs) begin
      pend[i] = 1'b0;
      rd_m[i] = 32'h0;
      rd_c[i] = 16'h0;
      wr_c[i] = 16'h0;
      er_c[i] = 16'h0;
    end
    e_rdy = pend[i] && (cyc == acc[i] + 1 + wc(i));
    e_bz  = pend[i] && (cyc >= acc[i] + 1) && (cyc <= acc[i] + 1 + wc(i));
    e_err = e_rdy && p_err[i];
    if (e_rdy) begin
      off = (p_addr[i] - BASE) / 4;
      if (p_err[i])     begin if (er_c[i] != 16'hFFFF) er_c[i]++; end
      else if (p_rd[i]) begin rd_m[i] = mem_m[i][off[7:0]]; if (rd_c[i] != 16'hFFFF) rd_c[i]++; end
      else              begin mem_m[i][off[7:0]] = p_data[i]; if (wr_c[i] != 16'hFFFF) wr_c[i]++; end
      pend[i] = 1'b0;
    end
    if (rdy === 1'b1) last_rdy_dut[i] = cyc;
    checkOutput((i == 0) ? "ready0" : "ready1", 32'(rdy), 32'(e_rdy));
    checkOutput((i == 0) ? "error0" : "error1", 32'(er), 32'(e_err));
    checkOutput((i == 0) ? "busy0" : "busy1", 32'(bz), 32'(e_bz));
    checkOutput((i == 0) ? "rdata0" : "rdata1", rdv, rd_m[i]);
`ifdef DMEM_STATS_EN
    checkOutput("rd_count", 32'(rc), 32'(rd_c[i]));
    checkOutput("wr_count", 32'(wcn), 32'(wr_c[i]));
    checkOutput("err_count", 32'(ec), 32'(er_c[i]));
`endif
  endtask

  // Compare process: capture the reset each edge saw, then check both
  // instances mid-cycle.
  initial begin
    bit r0, r1;
    forever begin
      @(posedge clock);
      cyc++;
      r0 = reset0;
      r1 = reset1;
      @(negedge clock);
`ifdef DMEM_STATS_EN
      cmp_inst(0, r0, rdata0, ready0, err0, busy0, rdc0, wrc0, erc0);
      cmp_inst(1, r1, rdata1, ready1, err1, busy1, rdc1, wrc1, erc1);
`else
      cmp_inst(0, r0, rdata0, ready0, err0, busy0);
      cmp_inst(1, r1, rdata1, ready1, err1, busy1);
`endif
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    reset0 = 1'b1;
    reset1 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset0 = 1'b0;
    reset1 = 1'b0;
    checkOutput("rst_rdata", rdata0, 32'h0);
    checkOutput("rst_ready", 32'(ready0), 32'h0);
    checkOutput("rst_busy", 32'(busy0), 32'h0);
    @(posedge clock); #1;

    applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, n);
    checkOutput("lat_wr", 32'(last_rdy_dut[0] - n), 32'd3);
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, n);
    checkOutput("lat_rd", 32'(last_rdy_dut[0] - n), 32'd3);
    checkOutput("rd_10", rdata0, 32'hDEAD_BEEF);

    applyStimulus(0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0, n);
    checkOutput("misalign_keep", rdata0, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, n);
    checkOutput("range_keep", rdata0, 32'hDEAD_BEEF);

    applyStimulus(0, 1'b0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 1'b0, n);
    applyStimulus(0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, n);
    checkOutput("rd_top", rdata0, 32'hCAFE_F00D);

    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0, n);
    applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 1'b0, n);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, n);
    checkOutput("rd_20", rdata0, 32'h1234_5678);

    // Abort a write in WAIT with a reset.
    applyStimulus(0, 1'b0, 1'b1, 32'h30, 32'hA5A5_0030, 1'b0, n);
    drive(0, 1'b0, 1'b1, 32'h30, 32'h1111_1111);
    model_request(0, 1'b0, 1'b1, 32'h30, 32'h1111_1111);
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset0 = 1'b1;
    @(posedge clock); #1;
    reset0 = 1'b0;
    checkOutput("abort_ready", 32'(ready0), 32'h0);
    checkOutput("abort_busy", 32'(busy0), 32'h0);
    checkOutput("abort_error", 32'(err0), 32'h0);
    checkOutput("abort_rdata", rdata0, 32'h0);
    @(posedge clock); #1;
    applyStimulus(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, n);
    checkOutput("rd_30_old", rdata0, 32'hA5A5_0030);

`ifdef DMEM_STATS_EN
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, n);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, n);
    applyStimulus(0, 1'b0, 1'b1, 32'h50, 32'h5050_5050, 1'b0, n);
    applyStimulus(0, 1'b0, 1'b1, 32'h54, 32'h5454_5454, 1'b0, n);
    applyStimulus(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0, n);
    checkOutput("stat_rd", 32'(rdc0), 32'd3);
    checkOutput("stat_wr", 32'(wrc0), 32'd2);
    checkOutput("stat_err", 32'(erc0), 32'd1);
    dut0.rd_count = 16'hFFFE;
    rd_c[0] = 16'hFFFE;
    repeat (3) applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, n);
    checkOutput("stat_sat", 32'(rdc0), 32'h0000_FFFF);
`endif

    // Zero wait states with requests held high back to back.
    applyStimulus(1, 1'b0, 1'b1, 32'h40, 32'h4040_4040, 1'b1, n);
    checkOutput("lat0_wr", 32'(last_rdy_dut[1] - n), 32'd1);
    applyStimulus(1, 1'b0, 1'b1, 32'h40, 32'h4040_4040, 1'b1, n);
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, n);
    applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, n);
    checkOutput("lat0_rd", 32'(last_rdy_dut[1] - n), 32'd1);
    checkOutput("rd0_40", rdata1, 32'h4040_4040);

    repeat (3) @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the CPU's load/store interface (MemRead, MemWrite, Address, Write_data, Read_data).
- Replaces the combinational data memory so the core can be moved to slower memory timing.
- Latches each request, inserts a configurable number of wait states, commits writes, returns read data, and flags illegal accesses with a one-cycle done pulse.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two.
- WAIT_CYCLES, 2, wait states between acceptance and response; 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word aligned.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- MemRead  input  1  read request; sampled only in IDLE.
- MemWrite  input  1  write request; sampled only in IDLE.
- Address  input  32  byte address of the request.
- Write_data  input  32  store data.
- Read_data  output  32  load data; valid when mem_ready=1 for a read; held until the next successful read.
- mem_ready  output  1  one-cycle response pulse.
- mem_error  output  1  valid with mem_ready; 1 means the access was rejected.
- busy  output  1  high in WAIT and RESP; low in IDLE.

Behaviour:
- Reset (synchronous, active-high): Read_data=0, mem_ready=0, mem_error=0, busy=0, state=IDLE, wait counter=0. RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If MemRead or MemWrite is high, latch op, Address and Write_data.
  - Go to WAIT with counter=WAIT_CYCLES-1, or go straight to RESP if WAIT_CYCLES=0.
- WAIT: decrement the counter; go to RESP when it reaches 0.
- RESP:
  - Assert mem_ready for exactly one cycle.
  - Reads: Read_data is updated on the edge entering RESP.
  - Writes: the RAM word is written on the edge entering RESP.
  - Return to IDLE. New requests are not sampled in RESP, so the minimum request spacing is WAIT_CYCLES+2 cycles.
- Latency: mem_ready is high WAIT_CYCLES+1 cycles after the accepting edge.
- Word index = (Address-BASE_ADDR)>>2, using the low log2(DEPTH_WORDS) bits after the range check.
- Error conditions, checked on the latched request:
  - Address[1:0] != 0.
  - Address < BASE_ADDR, or index >= DEPTH_WORDS. Unsigned subtraction; wrap-around counts as out of range.
  - MemRead and MemWrite both high.
- On error: full latency still applies, mem_ready=1 with mem_error=1, no RAM write, Read_data unchanged.
- Input changes during WAIT/RESP have no effect; the request is latched at acceptance.
- Reset mid-operation: a request in WAIT is aborted with no write and no mem_ready. Reset in the RESP cycle forces outputs to their reset values on that edge.
- Highest address (BASE_ADDR+4*DEPTH_WORDS-4) is legal; the next word is an error.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0], wr_count[15:0] and err_count[15:0], cleared by Reset.
  - Each counter increments on the mem_ready cycle of its response class: successful read, successful write, or any error.
  - Counters saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dmem_pkg:
  - State enum {IDLE, WAIT, RESP}.
  - DATA_W=32, ADDR_W=32, CNT_W=16.
  - Op encoding {OP_RD, OP_WR, OP_BAD}.
- One sub-module, dmem_storage: DEPTH_WORDS x 32 synchronous-write array with registered read port, instantiated by dmem_responder. FSM, range checking and optional counters remain in the top.

Test Plan:
- Reset, then write 32'hDEAD_BEEF to Address 32'h10 and read it back (WAIT_CYCLES=2) -> each mem_ready occurs 3 cycles after acceptance, mem_error=0, Read_data=32'hDEAD_BEEF.
- Read from 32'h12 (misaligned) and read from 32'h400 (DEPTH_WORDS=256) -> mem_ready with mem_error=1 for both; Read_data keeps its previous value.
- MemRead=MemWrite=1 to 32'h20 holding 32'h1234_5678 -> mem_error=1; a following read of 32'h20 returns 32'h1234_5678.
- WAIT_CYCLES=0, back-to-back requests held high -> mem_ready 1 cycle after each acceptance; accepts every 2 cycles; busy pattern 1,0,1,0.
- Write to 32'h30 with Reset asserted during WAIT -> no mem_ready; a later read of 32'h30 returns its pre-write value; all outputs 0 right after reset.
- DMEM_STATS_EN defined: 3 reads, 2 writes, 1 misaligned access -> rd_count=3, wr_count=2, err_count=1. Preload rd_count at 16'hFFFE and do 3 reads -> rd_count=16'hFFFF.
